// File: rtl/sound_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : sound_scheduler
// Description : Shares one square-wave tone generator between background
//               music and NUM_REQ prioritised sound-effect requesters.
//               Effects preempt music, play for a programmed number of
//               duration ticks and are followed by a silent gap.
// Ports       :
//    clk             system clock
//    rst_n           asynchronous active-low reset
//    i_music_enable  background music allowed
//    i_music_note    current background music note code
//    i_req           level request per effect, held until acked
//    i_req_note      note code per requester, slice i = [8i+7:8i]
//    i_req_dur       duration in ticks per requester
//    o_ack           one-cycle one-hot grant pulse
//    o_busy          effect or gap in progress
//    o_active_id     index of the granted/playing requester
//    o_note_out      note code to tone generator (0 = rest)
//    o_tone_enable   tone generator enable
// Revision    : 1.0 - initial release
// ============================================================================
module sound_scheduler #(
   parameter  int NUM_REQ   = 4,
   parameter  int TICK_DIV  = 1000000,
   parameter  int DUR_W     = 8,
   parameter  int GAP_TICKS = 1,
   localparam int ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_music_enable,
   input  logic [7:0]               i_music_note,
   input  logic [NUM_REQ-1:0]       i_req,
   input  logic [8*NUM_REQ-1:0]     i_req_note,
   input  logic [DUR_W*NUM_REQ-1:0] i_req_dur,
   output logic [NUM_REQ-1:0]       o_ack,
   output logic                     o_busy,
   output logic [ID_W-1:0]          o_active_id,
   output logic [7:0]               o_note_out,
   output logic                     o_tone_enable
);

   localparam int TW = $clog2(TICK_DIV);
   localparam int GW = $clog2(GAP_TICKS + 1);
   localparam logic [TW-1:0] C_TICK_MAX = TW'(TICK_DIV - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PLAY = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

   state_t              r_state, w_state_n;
   logic [TW-1:0]       r_tick_cnt, w_tick_cnt_n;
   logic [DUR_W-1:0]    r_dur_cnt, w_dur_cnt_n;
   logic [GW-1:0]       r_gap_cnt, w_gap_cnt_n;
   logic [NUM_REQ-1:0]  r_ack, w_ack_n;
   logic                r_busy, w_busy_n;
   logic [ID_W-1:0]     r_active_id, w_active_id_n;
   logic [7:0]          r_note, w_note_n;
   logic                r_tone_en, w_tone_en_n;

   logic                w_tick;
   logic                w_any_req;
   logic [ID_W-1:0]     w_win;
   logic [NUM_REQ-1:0]  w_win_oh;
   logic [7:0]          w_win_note;
   logic [DUR_W-1:0]    w_win_dur;
   logic                w_grant;
   logic                w_music;

   assign w_tick    = (r_tick_cnt == C_TICK_MAX);
   assign w_any_req = |i_req;

   // Lowest index wins: scan from the top so lower indices overwrite.
   always_comb begin
      w_win      = '0;
      w_win_oh   = '0;
      w_win_note = '0;
      w_win_dur  = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (i_req[i]) begin
            w_win      = ID_W'(i);
            w_win_oh   = '0;
            w_win_oh[i] = 1'b1;
            w_win_note = i_req_note[i*8 +: 8];
            w_win_dur  = i_req_dur[i*DUR_W +: DUR_W];
         end
      end
   end

   always_comb begin
      w_state_n     = r_state;
      w_tick_cnt_n  = w_tick ? '0 : r_tick_cnt + TW'(1);
      w_dur_cnt_n   = r_dur_cnt;
      w_gap_cnt_n   = r_gap_cnt;
      w_ack_n       = '0;
      w_busy_n      = r_busy;
      w_active_id_n = r_active_id;
      w_note_n      = r_note;
      w_tone_en_n   = r_tone_en;
      w_grant       = 1'b0;
      w_music       = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (w_any_req) w_grant = 1'b1;
            else           w_music = 1'b1;
         end
         ST_PLAY: begin
            // Preemption takes precedence over a coincident final tick.
            if (w_any_req && (w_win < r_active_id)) begin
               w_grant = 1'b1;
            end else if (w_tick) begin
               w_dur_cnt_n = r_dur_cnt - DUR_W'(1);
               if (r_dur_cnt == DUR_W'(1)) begin
                  w_state_n    = ST_GAP;
                  w_tick_cnt_n = '0;
                  w_gap_cnt_n  = GW'(GAP_TICKS);
                  w_note_n     = 8'h00;
                  w_tone_en_n  = 1'b0;
               end
            end
         end
         ST_GAP: begin
            // The last gap tick edge behaves like IDLE, so the gap lasts
            // exactly GAP_TICKS*TICK_DIV cycles.
            if (w_tick) begin
               if (r_gap_cnt == GW'(1)) begin
                  if (w_any_req) w_grant = 1'b1;
                  else           w_music = 1'b1;
               end else begin
                  w_gap_cnt_n = r_gap_cnt - GW'(1);
               end
            end
         end
         default: begin
            w_state_n = ST_IDLE;
            w_music   = 1'b1;
         end
      endcase

      if (w_grant) begin
         w_state_n     = ST_PLAY;
         w_ack_n       = w_win_oh;
         w_active_id_n = w_win;
         w_note_n      = w_win_note;
         w_tone_en_n   = 1'b1;
         w_busy_n      = 1'b1;
         w_dur_cnt_n   = (w_win_dur == '0) ? DUR_W'(1) : w_win_dur;
         w_tick_cnt_n  = '0;
      end else if (w_music) begin
         w_state_n   = ST_IDLE;
         w_busy_n    = 1'b0;
         w_note_n    = i_music_enable ? i_music_note : 8'h00;
         w_tone_en_n = i_music_enable;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_tick_cnt  <= '0;
         r_dur_cnt   <= '0;
         r_gap_cnt   <= '0;
         r_ack       <= '0;
         r_busy      <= 1'b0;
         r_active_id <= '0;
         r_note      <= 8'h00;
         r_tone_en   <= 1'b0;
      end else begin
         r_state     <= w_state_n;
         r_tick_cnt  <= w_tick_cnt_n;
         r_dur_cnt   <= w_dur_cnt_n;
         r_gap_cnt   <= w_gap_cnt_n;
         r_ack       <= w_ack_n;
         r_busy      <= w_busy_n;
         r_active_id <= w_active_id_n;
         r_note      <= w_note_n;
         r_tone_en   <= w_tone_en_n;
      end
   end

   assign o_ack         = r_ack;
   assign o_busy        = r_busy;
   assign o_active_id   = r_active_id;
   assign o_note_out    = r_note;
   assign o_tone_enable = r_tone_en;

endmodule
`default_nettype wire

// File: tb/tb_sound_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_sound_scheduler
// Description : Directed self-checking bench for sound_scheduler with
//               TICK_DIV=4, GAP_TICKS=1, NUM_REQ=4, DUR_W=8.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sound_scheduler;

   logic        clk;
   logic        rst_n;
   logic        r_music_en;
   logic [7:0]  r_music_note;
   logic [3:0]  r_req;
   logic [31:0] r_req_note;
   logic [31:0] r_req_dur;
   logic [3:0]  w_ack;
   logic        w_busy;
   logic [1:0]  w_active_id;
   logic [7:0]  w_note;
   logic        w_tone_en;

   int n_cmp;
   int n_bad;

   sound_scheduler #(
      .NUM_REQ   (4),
      .TICK_DIV  (4),
      .DUR_W     (8),
      .GAP_TICKS (1)
   ) u_dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .i_music_enable (r_music_en),
      .i_music_note   (r_music_note),
      .i_req          (r_req),
      .i_req_note     (r_req_note),
      .i_req_dur      (r_req_dur),
      .o_ack          (w_ack),
      .o_busy         (w_busy),
      .o_active_id    (w_active_id),
      .o_note_out     (w_note),
      .o_tone_enable  (w_tone_en)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Advance to 1 time unit after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic set_req(input int idx, input logic [7:0] note, input logic [7:0] dur);
      r_req_note[idx*8 +: 8] = note;
      r_req_dur[idx*8 +: 8]  = dur;
   endtask

   initial begin
      n_cmp        = 0;
      n_bad        = 0;
      rst_n        = 1'b0;
      r_music_en   = 1'b1;
      r_music_note = 8'h19;
      r_req        = 4'b0000;
      r_req_note   = '0;
      r_req_dur    = '0;

      // ---------------- reset and music ----------------
      step();
      check_eq("rst_note", w_note, 8'h00);
      check_eq("rst_ten",  w_tone_en, 1'b0);
      check_eq("rst_busy", w_busy, 1'b0);
      check_eq("rst_ack",  w_ack, 4'b0000);
      check_eq("rst_id",   w_active_id, 2'd0);
      rst_n = 1'b1;
      step();
      check_eq("music_note", w_note, 8'h19);
      check_eq("music_ten",  w_tone_en, 1'b1);
      check_eq("music_busy", w_busy, 1'b0);

      // ---------------- single effect ----------------
      set_req(2, 8'h2A, 8'd3);
      r_req = 4'b0100;
      step();
      check_eq("single_ack",  w_ack, 4'b0100);
      check_eq("single_note", w_note, 8'h2A);
      check_eq("single_id",   w_active_id, 2'd2);
      check_eq("single_busy", w_busy, 1'b1);
      r_req = 4'b0000;
      for (int k = 1; k < 12; k++) begin
         step();
         check_eq("single_play_note", w_note, 8'h2A);
         check_eq("single_play_ack",  w_ack, 4'b0000);
      end
      for (int k = 0; k < 4; k++) begin
         step();
         check_eq("single_gap_note", w_note, 8'h00);
         check_eq("single_gap_ten",  w_tone_en, 1'b0);
         check_eq("single_gap_busy", w_busy, 1'b1);
      end
      step();
      check_eq("single_music_note", w_note, 8'h19);
      check_eq("single_music_busy", w_busy, 1'b0);

      // ---------------- priority ----------------
      set_req(1, 8'h11, 8'd1);
      set_req(3, 8'h33, 8'd1);
      r_req = 4'b1010;
      step();
      check_eq("prio_ack1", w_ack, 4'b0010);
      check_eq("prio_id1",  w_active_id, 2'd1);
      check_eq("prio_note1", w_note, 8'h11);
      r_req = 4'b1000;
      steps(3);
      check_eq("prio_wait_note", w_note, 8'h11);
      for (int k = 0; k < 4; k++) begin
         step();
         check_eq("prio_gap_ack",  w_ack, 4'b0000);
         check_eq("prio_gap_note", w_note, 8'h00);
      end
      step();
      check_eq("prio_ack3",  w_ack, 4'b1000);
      check_eq("prio_id3",   w_active_id, 2'd3);
      check_eq("prio_note3", w_note, 8'h33);
      r_req = 4'b0000;
      steps(8);
      check_eq("prio_music", w_note, 8'h19);

      // ---------------- preemption ----------------
      set_req(2, 8'h2A, 8'd10);
      set_req(0, 8'h05, 8'd2);
      r_req = 4'b0100;
      step();
      check_eq("pre_ack2", w_ack, 4'b0100);
      r_req = 4'b0000;
      steps(2);
      r_req = 4'b0001;
      step();
      check_eq("pre_ack0",  w_ack, 4'b0001);
      check_eq("pre_note0", w_note, 8'h05);
      check_eq("pre_id0",   w_active_id, 2'd0);
      check_eq("pre_ten",   w_tone_en, 1'b1);
      r_req = 4'b0000;
      for (int k = 1; k < 8; k++) begin
         step();
         check_eq("pre_play_note", w_note, 8'h05);
      end
      for (int k = 0; k < 4; k++) begin
         step();
         check_eq("pre_gap_note", w_note, 8'h00);
         check_eq("pre_gap_ack",  w_ack, 4'b0000);
      end
      step();
      check_eq("pre_music_note", w_note, 8'h19);
      check_eq("pre_no_reack",   w_ack, 4'b0000);
      check_eq("pre_music_busy", w_busy, 1'b0);

      // ---------------- zero duration ----------------
      set_req(1, 8'h44, 8'd0);
      r_req = 4'b0010;
      step();
      check_eq("zero_ack", w_ack, 4'b0010);
      r_req = 4'b0000;
      steps(3);
      check_eq("zero_last_note", w_note, 8'h44);
      step();
      check_eq("zero_gap_note", w_note, 8'h00);
      check_eq("zero_gap_ten",  w_tone_en, 1'b0);
      steps(4);
      check_eq("zero_music", w_note, 8'h19);

      // ---------------- final tick coincides with preemption ----------------
      set_req(3, 8'h33, 8'd1);
      set_req(0, 8'h05, 8'd1);
      r_req = 4'b1000;
      step();
      check_eq("coin_ack3", w_ack, 4'b1000);
      r_req = 4'b0000;
      steps(3);
      r_req = 4'b0001;
      step();
      check_eq("coin_ack0", w_ack, 4'b0001);
      check_eq("coin_note", w_note, 8'h05);
      check_eq("coin_ten",  w_tone_en, 1'b1);
      r_req = 4'b0000;
      steps(8);
      check_eq("coin_music", w_note, 8'h19);

      // ---------------- music disabled ----------------
      r_music_en = 1'b0;
      step();
      check_eq("mdis_note", w_note, 8'h00);
      check_eq("mdis_ten",  w_tone_en, 1'b0);
      r_music_en = 1'b1;
      step();
      check_eq("men_note", w_note, 8'h19);

      // ---------------- reset mid-effect ----------------
      set_req(2, 8'h2A, 8'd3);
      r_req = 4'b0100;
      step();
      check_eq("mrst_ack", w_ack, 4'b0100);
      r_req = 4'b0000;
      steps(2);
      rst_n = 1'b0;
      #2;
      check_eq("mrst_note", w_note, 8'h00);
      check_eq("mrst_ten",  w_tone_en, 1'b0);
      check_eq("mrst_busy", w_busy, 1'b0);
      step();
      rst_n = 1'b1;
      step();
      check_eq("mrst_idle_note", w_note, 8'h19);
      check_eq("mrst_idle_ack",  w_ack, 4'b0000);
      check_eq("mrst_idle_busy", w_busy, 1'b0);
      step();
      check_eq("mrst_no_ack", w_ack, 4'b0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
